// File: rtl/decode_stage_if.sv
// ---------------------------------------------------------------------------
// decode_stage_if
//   Bundles the fetch-side handshake, the flush control and the alu-side
//   decoded bus of the decode stage.
//
//   modport slave  : the decode stage itself
//                    in : flush, in_valid, in_instr, in_pc, out_ready
//                    out: in_ready, out_valid, regA, regB, rs2, opcode,
//                         regDest, uimm, o_pc, wr_req, illegal
//   modport master : the surrounding pipeline (fetch + alu), with the
//                    directions reversed
//
//   PC_W : width of in_pc / o_pc
// ---------------------------------------------------------------------------
interface decode_stage_if #(
  parameter int PC_W = 32
);
  // fetch side
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;

  // alu side
  logic            out_valid;
  logic            out_ready;
  logic [4:0]      regA;
  logic [11:0]     regB;
  logic [4:0]      rs2;
  logic [9:0]      opcode;
  logic [4:0]      regDest;
  logic [19:0]     uimm;
  logic [PC_W-1:0] o_pc;
  logic            wr_req;
  logic            illegal;

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, regA, regB, rs2, opcode, regDest, uimm,
           o_pc, wr_req, illegal
  );

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, regA, regB, rs2, opcode, regDest, uimm,
           o_pc, wr_req, illegal
  );
endinterface

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//   RV64 instruction decode between fetch and alu. One instruction + PC is
//   accepted per cycle, split combinationally into the alu field set and
//   held in a 2-entry skid buffer (output register + skid register) with
//   valid/ready handshakes on both sides.
//
// Parameters
//   PC_W          : PC width
//   CHECK_ILLEGAL : 1 flags unsupported major opcodes, 0 ties illegal low
//
// Ports
//   clk   : clock, all state on the rising edge
//   reset : synchronous, active-high; clears both entries and the payload
//   bus   : decode_stage_if.slave (fetch handshake, flush, decoded bus)
//
// Decoded fields
//   regA    = instr[19:15]            rs2 = instr[24:20]
//   regB    = I-layout instr[31:20] by default; S and B immediates for
//             stores / branches (B carries imm[12:1])
//   opcode  = {funct3, opcode7}, funct3 zeroed for LUI/AUIPC/JAL
//   regDest = instr[11:7], zero for stores, branches, FENCE and illegal
//   uimm    = U immediate or J imm[20:1], zero otherwise
//   wr_req  = instruction writes a register and regDest != 0
// ---------------------------------------------------------------------------
module decode_stage #(
  parameter int PC_W          = 32,
  parameter bit CHECK_ILLEGAL = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  decode_stage_if.slave        bus
);

  // major opcodes
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_IMM32  = 7'h1B;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_REG32  = 7'h3B;
  localparam logic [6:0] OP_FENCE  = 7'h0F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  // one buffered, already-decoded instruction
  typedef struct packed {
    logic [4:0]      reg_a;
    logic [11:0]     reg_b;
    logic [4:0]      rs2;
    logic [9:0]      opcode;
    logic [4:0]      reg_dest;
    logic [19:0]     uimm;
    logic [PC_W-1:0] pc;
    logic            wr_req;
    logic            illegal;
  } entry_t;

  logic [31:0] instr_s;
  logic        writes_s;
  entry_t      dec_s;

  entry_t      out_r;
  entry_t      skid_r;
  logic        out_valid_r;
  logic        skid_valid_r;

  logic        accept_s;
  logic        drain_s;
  logic        load_out_s;
  logic        load_skid_s;

  // Combinational decode of the offered instruction. Unknown opcodes keep
  // the I-layout fields but never request a writeback.
  always_comb begin
    instr_s         = bus.in_instr;
    writes_s        = 1'b0;
    dec_s           = '0;
    dec_s.reg_a     = instr_s[19:15];
    dec_s.reg_b     = instr_s[31:20];
    dec_s.rs2       = instr_s[24:20];
    dec_s.opcode    = {instr_s[14:12], instr_s[6:0]};
    dec_s.reg_dest  = instr_s[11:7];
    dec_s.uimm      = 20'h00000;
    dec_s.pc        = bus.in_pc;
    dec_s.illegal   = 1'b0;
    case (instr_s[6:0])
      OP_LUI, OP_AUIPC: begin
        dec_s.opcode = {3'b000, instr_s[6:0]};
        dec_s.uimm   = instr_s[31:12];
        writes_s     = 1'b1;
      end
      OP_JAL: begin
        dec_s.opcode = {3'b000, instr_s[6:0]};
        dec_s.uimm   = {instr_s[31], instr_s[19:12], instr_s[20], instr_s[30:21]};
        writes_s     = 1'b1;
      end
      OP_JALR, OP_LOAD, OP_IMM, OP_IMM32, OP_REG, OP_REG32: begin
        writes_s = 1'b1;
      end
      OP_BRANCH: begin
        dec_s.reg_b    = {instr_s[31], instr_s[7], instr_s[30:25], instr_s[11:8]};
        dec_s.reg_dest = 5'd0;
      end
      OP_STORE: begin
        dec_s.reg_b    = {instr_s[31:25], instr_s[11:7]};
        dec_s.reg_dest = 5'd0;
      end
      OP_FENCE: begin
        dec_s.reg_dest = 5'd0;
      end
      OP_SYSTEM: begin
        // only the CSR forms (funct3 != 0) return a value
        writes_s = (instr_s[14:12] != 3'b000);
      end
      default: begin
        dec_s.reg_dest = 5'd0;
        dec_s.illegal  = CHECK_ILLEGAL;
      end
    endcase
    dec_s.wr_req = writes_s & (dec_s.reg_dest != 5'd0);
  end

  // Handshake terms. in_ready is the inverse of a register, so it never
  // depends combinationally on out_ready.
  always_comb begin
    accept_s    = bus.in_valid & ~skid_valid_r & ~bus.flush;
    drain_s     = out_valid_r & bus.out_ready;
    load_out_s  = ~out_valid_r | drain_s;
    load_skid_s = accept_s & out_valid_r & ~bus.out_ready;
  end

  // Two-entry buffer: the skid entry always drains into the output entry
  // before new input is taken there, which keeps program order.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
      out_r        <= '0;
      skid_r       <= '0;
    end else if (bus.flush) begin
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (load_out_s) begin
      if (skid_valid_r) begin
        out_r        <= skid_r;
        out_valid_r  <= 1'b1;
        skid_valid_r <= 1'b0;
      end else if (accept_s) begin
        out_r        <= dec_s;
        out_valid_r  <= 1'b1;
      end else begin
        out_valid_r  <= 1'b0;
      end
    end else if (load_skid_s) begin
      skid_r       <= dec_s;
      skid_valid_r <= 1'b1;
    end else begin
      skid_valid_r <= skid_valid_r;
    end
  end

  assign bus.in_ready  = ~skid_valid_r;
  assign bus.out_valid = out_valid_r;
  assign bus.regA      = out_r.reg_a;
  assign bus.regB      = out_r.reg_b;
  assign bus.rs2       = out_r.rs2;
  assign bus.opcode    = out_r.opcode;
  assign bus.regDest   = out_r.reg_dest;
  assign bus.uimm      = out_r.uimm;
  assign bus.o_pc      = out_r.pc;
  assign bus.wr_req    = out_r.wr_req;
  assign bus.illegal   = out_r.illegal;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
  localparam int PC_W = 32;
  localparam int NV   = 13;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_stage_if #(.PC_W(PC_W)) bus ();
  decode_stage #(.PC_W(PC_W), .CHECK_ILLEGAL(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  ra;
    logic [11:0] rb;
    logic [4:0]  rs2;
    logic [9:0]  opc;
    logic [4:0]  rd;
    logic [19:0] uimm;
    logic        wr;
    logic        ill;
  } vec_t;

  vec_t vecs [NV];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // {valid, regA, regB, rs2, opcode, regDest, uimm, wr_req, illegal}
  function automatic logic [59:0] got();
    return {bus.out_valid, bus.regA, bus.regB, bus.rs2, bus.opcode,
            bus.regDest, bus.uimm, bus.wr_req, bus.illegal};
  endfunction

  function automatic logic [59:0] exp_of(input vec_t v);
    return {1'b1, v.ra, v.rb, v.rs2, v.opc, v.rd, v.uimm, v.wr, v.ill};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
  endtask

  initial begin
    //          instr         ra     rb       rs2     opc      rd      uimm       wr    ill
    vecs[0]  = '{32'hFFD08293, 5'd1,  12'hFFD, 5'd29, 10'h013, 5'd5,  20'h00000, 1'b1, 1'b0}; // addi x5,x1,-3
    vecs[1]  = '{32'h00208463, 5'd1,  12'h004, 5'd2,  10'h063, 5'd0,  20'h00000, 1'b0, 1'b0}; // beq +8
    vecs[2]  = '{32'h123451B7, 5'd8,  12'h123, 5'd3,  10'h037, 5'd3,  20'h12345, 1'b1, 1'b0}; // lui
    vecs[3]  = '{32'h0020A423, 5'd1,  12'h008, 5'd2,  10'h123, 5'd0,  20'h00000, 1'b0, 1'b0}; // sw x2,8(x1)
    vecs[4]  = '{32'h010000EF, 5'd0,  12'h010, 5'd16, 10'h06F, 5'd1,  20'h00008, 1'b1, 1'b0}; // jal x1,+16
    vecs[5]  = '{32'h00208033, 5'd1,  12'h002, 5'd2,  10'h033, 5'd0,  20'h00000, 1'b0, 1'b0}; // add x0
    vecs[6]  = '{32'h300093F3, 5'd1,  12'h300, 5'd0,  10'h0F3, 5'd7,  20'h00000, 1'b1, 1'b0}; // csrrw x7
    vecs[7]  = '{32'h00000073, 5'd0,  12'h000, 5'd0,  10'h073, 5'd0,  20'h00000, 1'b0, 1'b0}; // ecall
    vecs[8]  = '{32'h0FF0008F, 5'd0,  12'h0FF, 5'd31, 10'h00F, 5'd0,  20'h00000, 1'b0, 1'b0}; // fence, rd field 1
    vecs[9]  = '{32'hABCDE517, 5'd27, 12'hABC, 5'd28, 10'h017, 5'd10, 20'hABCDE, 1'b1, 1'b0}; // auipc x10
    vecs[10] = '{32'h0000007F, 5'd0,  12'h000, 5'd0,  10'h07F, 5'd0,  20'h00000, 1'b0, 1'b1}; // illegal
    vecs[11] = '{32'hFE000EE3, 5'd0,  12'hFFE, 5'd0,  10'h063, 5'd0,  20'h00000, 1'b0, 1'b0}; // beq -4
    vecs[12] = '{32'h801FF0EF, 5'd31, 12'h801, 5'd1,  10'h06F, 5'd1,  20'hFFC00, 1'b1, 1'b0}; // jal mixed imm

    // reset with input offered: input must be ignored
    reset         = 1'b1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    offer(32'hFFD08293, 32'h40);
    step();
    step();
    chk("reset_fields", {4'b0, got()}, 64'd0);
    chk("reset_pc", 64'(bus.o_pc), 64'd0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    step();
    chk("idle_valid", 64'(bus.out_valid), 64'd0);

    // table: one instruction per cycle with out_ready high
    for (int i = 0; i < NV; i++) begin
      offer(vecs[i].instr, 32'h1000 + 32'(i * 4));
      step();
      chk($sformatf("vec%0d_fields", i), {4'b0, got()}, {4'b0, exp_of(vecs[i])});
      chk($sformatf("vec%0d_pc", i), 64'(bus.o_pc), 64'(32'h1000 + 32'(i * 4)));
    end
    bus.in_valid = 1'b0;
    step();
    chk("table_drained", 64'(bus.out_valid), 64'd0);

    // backpressure: A out, B in skid, C held off, then in-order drain
    bus.out_ready = 1'b0;
    offer(vecs[0].instr, 32'h2000);
    step();
    offer(vecs[1].instr, 32'h2004);
    step();
    chk("bp_full_in_ready", 64'(bus.in_ready), 64'd0);
    chk("bp_hold_a", {4'b0, got()}, {4'b0, exp_of(vecs[0])});
    offer(vecs[2].instr, 32'h2008);
    step();
    chk("bp_still_a", {4'b0, got()}, {4'b0, exp_of(vecs[0])});
    chk("bp_still_a_pc", 64'(bus.o_pc), 64'(32'h2000));
    chk("bp_c_blocked", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    step();
    chk("bp_emit_b", {4'b0, got()}, {4'b0, exp_of(vecs[1])});
    chk("bp_emit_b_pc", 64'(bus.o_pc), 64'(32'h2004));
    chk("bp_ready_again", 64'(bus.in_ready), 64'd1);
    step();
    chk("bp_emit_c", {4'b0, got()}, {4'b0, exp_of(vecs[2])});
    chk("bp_emit_c_pc", 64'(bus.o_pc), 64'(32'h2008));
    bus.in_valid = 1'b0;
    step();
    chk("bp_empty", 64'(bus.out_valid), 64'd0);

    // flush with both entries full and a new instruction offered
    bus.out_ready = 1'b0;
    offer(vecs[3].instr, 32'h3000);
    step();
    offer(vecs[4].instr, 32'h3004);
    step();
    chk("fl_full", 64'(bus.in_ready), 64'd0);
    bus.flush = 1'b1;
    offer(vecs[5].instr, 32'h3008);
    step();
    chk("fl_valid", 64'(bus.out_valid), 64'd0);
    chk("fl_in_ready", 64'(bus.in_ready), 64'd1);
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("fl_dropped", 64'(bus.out_valid), 64'd0);

    // reset mid-stream with both entries full
    bus.out_ready = 1'b0;
    offer(vecs[6].instr, 32'h4000);
    step();
    offer(vecs[9].instr, 32'h4004);
    step();
    reset = 1'b1;
    offer(vecs[10].instr, 32'h4008);
    step();
    chk("rs_fields", {4'b0, got()}, 64'd0);
    chk("rs_pc", 64'(bus.o_pc), 64'd0);
    chk("rs_in_ready", 64'(bus.in_ready), 64'd1);
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    offer(vecs[2].instr, 32'h5000);
    step();
    chk("rs_recover", {4'b0, got()}, {4'b0, exp_of(vecs[2])});
    chk("rs_recover_pc", 64'(bus.o_pc), 64'(32'h5000));
    bus.in_valid = 1'b0;
    step();
    chk("rs_end_empty", 64'(bus.out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
